// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for the 1M x 16 asynchronous SRAM.
// Grants one halfword read/write at a time and sequences the SRAM pins through
// SETUP (1 clk) -> ACCESS (WAIT_CYCLES clks) -> DONE (1 clk).
//
// Ports:
//   CLOCK_50, reset_n         clock, async active-low reset
//   pN_req_*                  request handshake + fields (N = 0 bridge, 1 loader)
//   pN_rsp_valid/rdata        completion pulse, read data (held until next read)
//   SRAM_*                    registered SRAM pins, SRAM_DQ tri-stated when idle
//   busy                      FSM not in IDLE
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [19:0] p0_req_addr,
    input  logic [15:0] p0_req_wdata,
    input  logic [1:0]  p0_req_be,
    output logic        p0_rsp_valid,
    output logic [15:0] p0_rsp_rdata,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [19:0] p1_req_addr,
    input  logic [15:0] p1_req_wdata,
    input  logic [1:0]  p1_req_be,
    output logic        p1_rsp_valid,
    output logic [15:0] p1_rsp_rdata,
    inout  wire  [15:0] SRAM_DQ,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        cur_port, cur_we;
    logic [1:0]  cur_be;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        take1, gnt0, gnt1, grant;
    logic        sel_we;
    logic [19:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [1:0]  sel_be;
    logic        f_we;
    logic [1:0]  f_be;
    logic [19:0] f_addr;
    logic [19:0] addr_n;
    logic        ce_n_n, oe_n_n, we_n_n, lb_n_n, ub_n_n, dq_oe_n;

    // take1: port 1 would win if the FSM were in IDLE this cycle.
`ifdef SRAM_ARB_RR_EN
    logic last;  // last-served port; reset to 1 so port 0 wins the first conflict

    assign take1 = p1_req_valid && (!p0_req_valid || !last);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)   last <= 1'b1;
        else if (grant) last <= gnt1;
    end
`else
    assign take1 = p1_req_valid && !p0_req_valid;
`endif

    // Gate with reset_n so no ready escapes while reset is held.
    assign gnt1  = reset_n && (state == IDLE) && take1;
    assign gnt0  = reset_n && (state == IDLE) && p0_req_valid && !take1;
    assign grant = gnt0 || gnt1;

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign p0_rsp_valid = (state == DONE) && !cur_port;
    assign p1_rsp_valid = (state == DONE) &&  cur_port;
    assign busy         = (state != IDLE);

    assign sel_we    = take1 ? p1_req_we    : p0_req_we;
    assign sel_addr  = take1 ? p1_req_addr  : p0_req_addr;
    assign sel_wdata = take1 ? p1_req_wdata : p0_req_wdata;
    assign sel_be    = take1 ? p1_req_be    : p0_req_be;

    // Fields for the pin registers: straight from the winner on the grant
    // cycle, from the latched copy afterwards (SRAM_ADDR itself holds the address).
    assign f_we   = (state == IDLE) ? sel_we   : cur_we;
    assign f_be   = (state == IDLE) ? sel_be   : cur_be;
    assign f_addr = (state == IDLE) ? sel_addr : SRAM_ADDR;

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant) state_n = SETUP;
            SETUP:   state_n = ACCESS;
            ACCESS:  if (cnt == 4'd1) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, so every
    // SRAM control changes only on a clock edge.
    always_comb begin
        addr_n  = SRAM_ADDR;
        ce_n_n  = 1'b1;
        oe_n_n  = 1'b1;
        we_n_n  = 1'b1;
        lb_n_n  = 1'b1;
        ub_n_n  = 1'b1;
        dq_oe_n = 1'b0;
        case (state_n)
            SETUP, ACCESS: begin
                addr_n  = f_addr;
                ce_n_n  = 1'b0;
                oe_n_n  = f_we;
                we_n_n  = !(f_we && (state_n == ACCESS));
                lb_n_n  = f_we ? ~f_be[0] : 1'b0;
                ub_n_n  = f_we ? ~f_be[1] : 1'b0;
                dq_oe_n = f_we;
            end
            DONE: begin
                // Write data hold: keep CE, byte lanes and DQ one more cycle.
                ce_n_n  = ~f_we;
                lb_n_n  = f_we ? ~f_be[0] : 1'b1;
                ub_n_n  = f_we ? ~f_be[1] : 1'b1;
                dq_oe_n = f_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cur_port     <= 1'b0;
            cur_we       <= 1'b0;
            cur_be       <= 2'b00;
            dq_out       <= 16'h0000;
            dq_oe        <= 1'b0;
            SRAM_ADDR    <= 20'h00000;
            SRAM_CE_N    <= 1'b1;
            SRAM_OE_N    <= 1'b1;
            SRAM_WE_N    <= 1'b1;
            SRAM_LB_N    <= 1'b1;
            SRAM_UB_N    <= 1'b1;
            p0_rsp_rdata <= 16'h0000;
            p1_rsp_rdata <= 16'h0000;
        end else begin
            state     <= state_n;
            SRAM_ADDR <= addr_n;
            SRAM_CE_N <= ce_n_n;
            SRAM_OE_N <= oe_n_n;
            SRAM_WE_N <= we_n_n;
            SRAM_LB_N <= lb_n_n;
            SRAM_UB_N <= ub_n_n;
            dq_oe     <= dq_oe_n;
            if (grant) begin
                cur_port <= gnt1;
                cur_we   <= sel_we;
                cur_be   <= sel_be;
                dq_out   <= sel_wdata;
            end
            if (state == SETUP)       cnt <= WAIT_LD;
            else if (state == ACCESS) cnt <= cnt - 4'd1;
            // Sample read data at the end of the last strobe cycle.
            if ((state == ACCESS) && (cnt == 4'd1) && !cur_we) begin
                if (cur_port) p1_rsp_rdata <= SRAM_DQ;
                else          p0_rsp_rdata <= SRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int W = 2;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // main DUT
    logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
    logic [19:0] p0_addr = 0, p1_addr = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0;
    logic [1:0]  p0_be = 0, p1_be = 0;
    logic        p0_ready, p1_ready, p0_rsp, p1_rsp;
    logic [15:0] p0_rdata, p1_rdata;
    wire  [15:0] sram_dq;
    logic [19:0] sram_addr;
    logic        ce_n, oe_n, we_n, lb_n, ub_n, busy;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .p0_req_valid(p0_valid), .p0_req_ready(p0_ready), .p0_req_we(p0_we),
        .p0_req_addr(p0_addr), .p0_req_wdata(p0_wdata), .p0_req_be(p0_be),
        .p0_rsp_valid(p0_rsp), .p0_rsp_rdata(p0_rdata),
        .p1_req_valid(p1_valid), .p1_req_ready(p1_ready), .p1_req_we(p1_we),
        .p1_req_addr(p1_addr), .p1_req_wdata(p1_wdata), .p1_req_be(p1_be),
        .p1_rsp_valid(p1_rsp), .p1_rsp_rdata(p1_rdata),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .busy(busy)
    );

    // SRAM model (low 10 address bits), written on the rising edge of WE_N.
    logic [15:0] mem [0:1023];
    logic [15:0] mem_q;
    assign mem_q = mem[sram_addr[9:0]];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem_q : 16'hzzzz;
    // Bus keeper used only in idle windows: reads 0 unless the DUT drives.
    logic keep_en = 1'b0;
    assign sram_dq = keep_en ? 16'h0000 : 16'hzzzz;

    always @(posedge we_n) begin
        if (ce_n === 1'b0) begin
            if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    // side DUTs for strobe-width extremes, port 0 writes only
    logic        s_valid = 0;
    logic        s1_ready, s1_rsp, s1_p1_ready, s1_p1_rsp, s1_ce, s1_oe, s1_we, s1_lb, s1_ub, s1_busy;
    logic        s15_ready, s15_rsp, s15_p1_ready, s15_p1_rsp, s15_ce, s15_oe, s15_we, s15_lb, s15_ub, s15_busy;
    logic [15:0] s1_rd0, s1_rd1, s15_rd0, s15_rd1;
    logic [19:0] s1_addr, s15_addr;
    wire  [15:0] s1_dq, s15_dq;

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .p0_req_valid(s_valid), .p0_req_ready(s1_ready), .p0_req_we(1'b1),
        .p0_req_addr(20'h00005), .p0_req_wdata(16'h1111), .p0_req_be(2'b11),
        .p0_rsp_valid(s1_rsp), .p0_rsp_rdata(s1_rd0),
        .p1_req_valid(1'b0), .p1_req_ready(s1_p1_ready), .p1_req_we(1'b0),
        .p1_req_addr(20'h0), .p1_req_wdata(16'h0), .p1_req_be(2'b00),
        .p1_rsp_valid(s1_p1_rsp), .p1_rsp_rdata(s1_rd1),
        .SRAM_DQ(s1_dq), .SRAM_ADDR(s1_addr), .SRAM_CE_N(s1_ce), .SRAM_OE_N(s1_oe),
        .SRAM_WE_N(s1_we), .SRAM_LB_N(s1_lb), .SRAM_UB_N(s1_ub), .busy(s1_busy)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .p0_req_valid(s_valid), .p0_req_ready(s15_ready), .p0_req_we(1'b1),
        .p0_req_addr(20'h00006), .p0_req_wdata(16'h2222), .p0_req_be(2'b11),
        .p0_rsp_valid(s15_rsp), .p0_rsp_rdata(s15_rd0),
        .p1_req_valid(1'b0), .p1_req_ready(s15_p1_ready), .p1_req_we(1'b0),
        .p1_req_addr(20'h0), .p1_req_wdata(16'h0), .p1_req_be(2'b00),
        .p1_rsp_valid(s15_p1_rsp), .p1_rsp_rdata(s15_rd1),
        .SRAM_DQ(s15_dq), .SRAM_ADDR(s15_addr), .SRAM_CE_N(s15_ce), .SRAM_OE_N(s15_oe),
        .SRAM_WE_N(s15_we), .SRAM_LB_N(s15_lb), .SRAM_UB_N(s15_ub), .busy(s15_busy)
    );

    // scoreboard
    typedef struct { bit we; logic [15:0] data; int cyc; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] sh [0:1023];      // shadow of SRAM contents
    logic [15:0] exp_rd0 = 0, exp_rd1 = 0;
    int glog[$];
    int last_gnt = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response/grant monitor, sampled mid-cycle after stimulus settles.
    always @(negedge CLOCK_50) begin
        exp_t e;
        #2;
        if (!reset_n) begin
            exp_rd0 = 0; exp_rd1 = 0; last_gnt = -1;
        end else begin
            if (p0_ready && p1_ready) chk("both_ready", 1, 0);
            if (p0_ready || p1_ready) begin
                glog.push_back(p1_ready ? 1 : 0);
                if (last_gnt >= 0) chk("gnt_gap", 32'(cyc - last_gnt >= W + 3), 1);
                last_gnt = cyc;
            end
            if (p0_rsp) begin
                if (q0.size() == 0) chk("p0_rsp_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("p0_rsp_cyc", cyc, e.cyc);
                    if (!e.we) exp_rd0 = e.data;
                    chk("p0_rdata", p0_rdata, exp_rd0);
                    chk("p1_rdata_kept", p1_rdata, exp_rd1);
                end
            end
            if (p1_rsp) begin
                if (q1.size() == 0) chk("p1_rsp_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("p1_rsp_cyc", cyc, e.cyc);
                    if (!e.we) exp_rd1 = e.data;
                    chk("p1_rdata", p1_rdata, exp_rd1);
                    chk("p0_rdata_kept", p0_rdata, exp_rd0);
                end
            end
        end
    end

    // Present a request at a negedge, wait for ready, push the expectation.
    // Returns at the negedge of cycle T+1 (SETUP) with valid dropped.
    task automatic issue(input bit port, input bit we, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] be, output int t);
        exp_t e;
        if (port) begin p1_valid = 1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be; end
        else      begin p0_valid = 1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be; end
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            #1;
            if (port ? p1_ready : p0_ready) t = cyc;
            @(negedge CLOCK_50);
        end
        if (port) p1_valid = 0; else p0_valid = 0;
        if (t < 0) chk("req_timeout", 0, 1);
        else begin
            e.we = we; e.cyc = t + 2 + W;
            if (we) begin
                if (be[0]) sh[a[9:0]][7:0]  = d[7:0];
                if (be[1]) sh[a[9:0]][15:8] = d[15:8];
                e.data = 16'h0;
            end else e.data = sh[a[9:0]];
            if (port) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin @(negedge CLOCK_50); n++; end
        if (busy) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge CLOCK_50);
    endtask

    initial begin
        int t;
        int exp_g[8];
        int g1a, g1b, r1, g15a, g15b, r15;
        for (int i = 0; i < 1024; i++) begin mem[i] = 16'h0; sh[i] = 16'h0; end

        // reset and idle
        keep_en = 1;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_we_n", we_n, 1);
        chk("rst_busy", busy, 0);
        reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50); #1;
            chk("idle_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
            chk("idle_dq", sram_dq, 16'h0000);
            chk("idle_busy", busy, 0);
            chk("idle_ready_rsp", {p0_ready, p1_ready, p0_rsp, p1_rsp}, 4'b0000);
            chk("idle_addr_rdata", {sram_addr, p0_rdata, p1_rdata}, 52'h0);
        end
        keep_en = 0;

        // full write then read
        issue(0, 1, 20'h00010, 16'hBEEF, 2'b11, t);
        #1;
        chk("wr_setup_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b01100);
        chk("wr_setup_addr", sram_addr, 20'h00010);
        chk("wr_setup_dq", sram_dq, 16'hBEEF);
        @(negedge CLOCK_50); #1; chk("wr_acc1_we_n", we_n, 0);
        @(negedge CLOCK_50); #1; chk("wr_acc2_we_n", we_n, 0);
        @(negedge CLOCK_50); #1; chk("wr_done_we_ce", {we_n, ce_n}, 2'b10);
        chk("wr_done_dq", sram_dq, 16'hBEEF);
        wait_idle();
        issue(0, 0, 20'h00010, 16'h0, 2'b00, t);
        #1; chk("rd_setup_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b00100);
        wait_idle();

        // low-byte write, read back merged halfword
        issue(0, 1, 20'h00010, 16'h1234, 2'b01, t);
        for (int i = 0; i < 3; i++) begin
            #1; chk("bl_ub_lb", {ub_n, lb_n}, 2'b10);
            @(negedge CLOCK_50);
        end
        wait_idle();
        issue(0, 0, 20'h00010, 16'h0, 2'b00, t);
        wait_idle();

        // no-byte write leaves memory untouched
        issue(0, 1, 20'h00020, 16'h5555, 2'b00, t);
        #1; chk("be0_lanes", {ub_n, lb_n}, 2'b11);
        wait_idle();
        issue(0, 0, 20'h00020, 16'h0, 2'b00, t);
        wait_idle();

        // port 1 traffic; port 0 read data must be held
        issue(1, 1, 20'h00030, 16'hCAFE, 2'b11, t);
        wait_idle();
        issue(1, 0, 20'h00030, 16'h0, 2'b00, t);
        wait_idle();

        // both ports issue continuous reads
        glog.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin int ta; issue(0, 0, 20'h00010, 16'h0, 2'b00, ta); end
            end
            begin
                for (int i = 0; i < 4; i++) begin int tb; issue(1, 0, 20'h00030, 16'h0, 2'b00, tb); end
            end
        join
        wait_idle();
`ifdef SRAM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        chk("gnt_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("gnt_order", glog[i], exp_g[i]);

        // reset during ACCESS of a write
        issue(0, 1, 20'h00040, 16'hF00D, 2'b11, t);
        @(negedge CLOCK_50); #1;
        chk("mid_we_n_low", we_n, 0);
        q0.delete();
        keep_en = 1;
        reset_n = 0;
        #1;
        chk("mid_rst_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        chk("mid_rst_dq", sram_dq, 16'h0000);
        chk("mid_rst_busy_addr", {busy, sram_addr}, 21'h0);
        @(negedge CLOCK_50);
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50); #1;
            chk("mid_no_rsp", {p0_rsp, busy}, 2'b00);
        end
        keep_en = 0;

        // strobe-width extremes
        g1a = -1; g1b = -1; r1 = -1; g15a = -1; g15b = -1; r15 = -1;
        s_valid = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (s1_ready)  begin if (g1a < 0)  g1a = cyc;  else if (g1b < 0)  g1b = cyc;  end
            if (s15_ready) begin if (g15a < 0) g15a = cyc; else if (g15b < 0) g15b = cyc; end
            if (s1_rsp  && r1 < 0)  r1 = cyc;
            if (s15_rsp && r15 < 0) r15 = cyc;
            @(negedge CLOCK_50);
        end
        s_valid = 0;
        chk("w1_granted", 32'(g1a >= 0 && g1b >= 0 && r1 >= 0), 1);
        chk("w15_granted", 32'(g15a >= 0 && g15b >= 0 && r15 >= 0), 1);
        chk("w1_rsp_lat", r1 - g1a, 3);
        chk("w15_rsp_lat", r15 - g15a, 17);
        chk("w1_next_gap", 32'(g1b - g1a >= 4), 1);
        chk("w15_next_gap", 32'(g15b - g15a >= 18), 1);

        chk("sb_empty", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the board's 16-bit asynchronous SRAM (1M × 16, SRAM_* pins of fpgaTop). It accepts halfword read/write requests from two on-chip requesters (port 0: core bus bridge; port 1: UART/debug loader), grants one at a time, and drives the SRAM address, control and tri-state data pins with fixed setup, strobe and hold phases. It sits between the requesters and the SRAM pins at the top level, clocked from CLOCK_50.

## Interface
Parameters:
- WAIT_CYCLES, 2: strobe width in clocks (OE_N/WE_N active phase); legal range 1–15.

Ports (N ∈ {0,1}):
- CLOCK_50  in  1  sole clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- pN_req_valid  in  1  request pending; must stay high with stable fields until pN_req_ready.
- pN_req_ready  out  1  request accepted this cycle.
- pN_req_we  in  1  1 = write, 0 = read.
- pN_req_addr  in  20  halfword address.
- pN_req_wdata  in  16  write data.
- pN_req_be  in  2  byte enables; bit0 = low byte, bit1 = high byte (writes only).
- pN_rsp_valid  out  1  one-cycle completion pulse (reads and writes).
- pN_rsp_rdata  out  16  read data; valid with rsp_valid, held until the next read on that port.
- SRAM_DQ  inout  16  data bus.
- SRAM_ADDR  out  20  address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low controls.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any pN_req_valid, pick a winner per arbitration, assert its pN_req_ready combinationally for that cycle, latch we/addr/wdata/be and the port id, go to SETUP. Otherwise stay. The loser sees no ready and keeps waiting.
- SETUP (1 cycle): SRAM_ADDR = latched addr, CE_N = 0, WE_N = 1. For a read, OE_N = 0 and LB_N = UB_N = 0. For a write, OE_N = 1, LB_N = ~be[0], UB_N = ~be[1], and DQ is driven with wdata.
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter): write, WE_N = 0; read, OE_N stays 0. On a read's final ACCESS cycle, SRAM_DQ is registered into the winner's rdata.
- DONE (1 cycle): WE_N = 1 and OE_N = 1. For a write, CE_N, ADDR and the DQ drive are held for data-hold time. The winner's rsp_valid pulses. Next state is IDLE.
- DQ is driven only in SETUP, ACCESS and DONE of a write; it is high-Z otherwise.
- All SRAM_* outputs are registered, so there are no glitches.
- be = 2'b00 write: the full cycle still runs with LB_N = UB_N = 1, so no bytes are written, and rsp_valid still pulses.
- rsp_rdata of the non-winning port is unchanged.

## Timing
- Acceptance at edge T (ready high in cycle T). SETUP in T+1, ACCESS in T+2 … T+1+WAIT_CYCLES, DONE and rsp_valid in T+2+WAIT_CYCLES.
- Back-to-back: the next ready is no earlier than T+3+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 clocks.
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, SRAM_ADDR = 0, CE_N = OE_N = WE_N = LB_N = UB_N = 1, DQ high-Z, busy = 0, state IDLE, last-served pointer = 1.
- Reset asserted mid-access: all outputs take their reset values immediately (asynchronously). The in-flight access is dropped with no rsp_valid. WE_N goes high at once, so a write may be partial.
- Simultaneous valid on both ports in IDLE: resolved per Configuration. Exactly one ready is ever asserted.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration. On a conflict, the port other than the last-served one wins. The pointer resets to 1, so port 0 wins the first conflict. The pointer updates on every grant.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins. Port 1 is served only when p0_req_valid is low in IDLE. No pointer register is generated.

## Test plan
- Reset then idle: all SRAM controls are 1, DQ is Z, busy = 0, no ready/rsp for 20 cycles.
- p0 write addr 0x00010, data 0xBEEF, be 2'b11, then p0 read of the same address (SRAM model attached, WAIT_CYCLES = 2):
  - write: ready at T, WE_N low in T+2..T+3, rsp_valid at T+4;
  - read: rsp_rdata = 0xBEEF with rsp_valid 4 cycles after its ready.
- Byte-lane write: be = 2'b01, data 0x1234 to an address holding 0xBEEF. Read back gives 0xBE34; UB_N = 1 throughout the write.
- Both ports issue continuous reads:
  - with SRAM_ARB_RR_EN, grants alternate 0,1,0,1;
  - without it, only port 0 is granted until p0_req_valid drops.
- reset_n pulled low during ACCESS of a write: WE_N/CE_N return to 1 in the same cycle, DQ goes Z, and no rsp_valid follows.
- WAIT_CYCLES = 1 and 15: rsp_valid at T+3 and T+17 respectively; the next ready is no earlier than T+4 / T+18.
